// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read controller.
// Holds the entry field types, the register address type, the controller
// state encoding and a saturating-counter helper.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    // One instruction-register entry as captured from a requester.
    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
    } instr_t;

    localparam int IR_DEPTH = 32;

    // Controller state codes, kept as plain constants for legacy users.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef enum logic [0:0] {
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH
    } ctrl_state_t;

    // Increment by one when inc is set, sticking at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
        logic [15:0] result;
        if (inc && (value != 16'hFFFF)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_register_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. When both requesters ask, the one that did
// not win last time (last: 0 = A, 1 = B) is granted. Purely combinational;
// the caller owns the last-grant register.
module rr_arbiter2 (
    input  logic valid_a,
    input  logic valid_b,
    input  logic enable,
    input  logic last,
    output logic grant_a,
    output logic grant_b
);

    // Pick at most one winner among the valid requesters.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!enable) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end else if (valid_a && valid_b) begin
            grant_a = last;
            grant_b = !last;
        end else begin
            grant_a = valid_a;
            grant_b = valid_b;
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Write/read controller for the instruction register.
// Arbitrates between requesters A and B, drives the register load port one
// cycle after acceptance, and sequences in-order draining through
// read_pointer with a valid/ready handshake. Owns pointers, occupancy and
// the RUN/FLUSH state.
// Optional build macro INSTR_CTRL_STATS_EN adds saturating grant and
// full-stall counters (grant_cnt_a, grant_cnt_b, full_stall_cnt).
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int DEPTH = IR_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  a_valid,
    input  logic                  b_valid,
    output logic                  a_ready,
    output logic                  b_ready,
    input  opcode_t               a_opcode,
    input  operand_t              a_operand_a,
    input  operand_t              a_operand_b,
    input  opcode_t               b_opcode,
    input  operand_t              b_operand_a,
    input  operand_t              b_operand_b,
    output logic                  load_en,
    output opcode_t               opcode,
    output operand_t              operand_a,
    output operand_t              operand_b,
    output address_t              write_pointer,
    output address_t              read_pointer,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  last_grant
`ifdef INSTR_CTRL_STATS_EN
    ,
    output logic [15:0]           grant_cnt_a,
    output logic [15:0]           grant_cnt_b,
    output logic [15:0]           full_stall_cnt
`endif
);

    localparam int             CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam address_t       PTR_LAST = address_t'(DEPTH - 1);

    // Pointers wrap at DEPTH, which may be smaller than the address space.
    function automatic address_t ptr_inc(input address_t ptr);
        address_t result;
        if (ptr == PTR_LAST) begin
            result = address_t'(0);
        end else begin
            result = ptr + address_t'(1);
        end
        return result;
    endfunction

    ctrl_state_t    state_r,      state_nxt;
    address_t       wr_ptr_r,     wr_ptr_nxt;
    address_t       rd_ptr_r,     rd_ptr_nxt;
    logic [CW-1:0]  count_r,      count_nxt;
    logic           load_en_r,    load_en_nxt;
    instr_t         data_r,       data_nxt;
    logic           last_grant_r, last_grant_nxt;
    logic           full_r,       full_nxt;
    logic           rd_valid_r,   rd_valid_nxt;

    logic           arb_en_s;
    logic           grant_a_s;
    logic           grant_b_s;
    logic           accept_s;
    logic           pop_s;

    // No grants while flushing, full or held in reset; full never bypasses a pop.
    assign arb_en_s = (state_r == RUN) && !full_r && !reset;

    rr_arbiter2 u_arb (
        .valid_a (a_valid),
        .valid_b (b_valid),
        .enable  (arb_en_s),
        .last    (last_grant_r),
        .grant_a (grant_a_s),
        .grant_b (grant_b_s)
    );

    assign a_ready  = grant_a_s;
    assign b_ready  = grant_b_s;
    assign accept_s = grant_a_s || grant_b_s;
    assign pop_s    = rd_valid_r && rd_ready;

    // Next-state logic for the FSM, pointers, occupancy and load port.
    always_comb begin
        state_nxt      = state_r;
        wr_ptr_nxt     = wr_ptr_r;
        rd_ptr_nxt     = rd_ptr_r;
        count_nxt      = count_r;
        load_en_nxt    = 1'b0;
        data_nxt       = data_r;
        last_grant_nxt = last_grant_r;
        case (state_r)
            RUN: begin
                if (flush) begin
                    // An in-flight write still lands this edge; its entry is discarded.
                    state_nxt   = FLUSH;
                    wr_ptr_nxt  = address_t'(0);
                    rd_ptr_nxt  = address_t'(0);
                    count_nxt   = CW'(0);
                    load_en_nxt = 1'b0;
                    if (accept_s) begin
                        last_grant_nxt = grant_b_s;
                    end else begin
                        last_grant_nxt = last_grant_r;
                    end
                end else begin
                    load_en_nxt = accept_s;
                    if (grant_b_s) begin
                        data_nxt       = '{opcode: b_opcode, operand_a: b_operand_a, operand_b: b_operand_b};
                        last_grant_nxt = 1'b1;
                    end else if (grant_a_s) begin
                        data_nxt       = '{opcode: a_opcode, operand_a: a_operand_a, operand_b: a_operand_b};
                        last_grant_nxt = 1'b0;
                    end else begin
                        data_nxt       = data_r;
                        last_grant_nxt = last_grant_r;
                    end
                    // The pending write commits on this edge, so the address moves on.
                    if (load_en_r) begin
                        wr_ptr_nxt = ptr_inc(wr_ptr_r);
                    end else begin
                        wr_ptr_nxt = wr_ptr_r;
                    end
                    if (pop_s) begin
                        rd_ptr_nxt = ptr_inc(rd_ptr_r);
                    end else begin
                        rd_ptr_nxt = rd_ptr_r;
                    end
                    case ({accept_s, pop_s})
                        2'b10:   count_nxt = count_r + CW'(1);
                        2'b01:   count_nxt = count_r - CW'(1);
                        default: count_nxt = count_r;
                    endcase
                end
            end
            FLUSH: begin
                state_nxt   = RUN;
                wr_ptr_nxt  = address_t'(0);
                rd_ptr_nxt  = address_t'(0);
                count_nxt   = CW'(0);
                load_en_nxt = 1'b0;
            end
            default: begin
                // Unreachable encoding: recover to an empty, running controller.
                state_nxt   = RUN;
                wr_ptr_nxt  = address_t'(0);
                rd_ptr_nxt  = address_t'(0);
                count_nxt   = CW'(0);
                load_en_nxt = 1'b0;
            end
        endcase
        full_nxt     = (count_nxt == DEPTH_C);
        // An entry is readable only once committed, so a pending load is excluded.
        rd_valid_nxt = (state_nxt == RUN) && (count_nxt > {{(CW-1){1'b0}}, load_en_nxt});
    end

    // State registers with synchronous reset; A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RUN;
            wr_ptr_r     <= address_t'(0);
            rd_ptr_r     <= address_t'(0);
            count_r      <= CW'(0);
            load_en_r    <= 1'b0;
            data_r       <= '{opcode: ZERO, operand_a: 32'sd0, operand_b: 32'sd0};
            last_grant_r <= 1'b1;
            full_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            wr_ptr_r     <= wr_ptr_nxt;
            rd_ptr_r     <= rd_ptr_nxt;
            count_r      <= count_nxt;
            load_en_r    <= load_en_nxt;
            data_r       <= data_nxt;
            last_grant_r <= last_grant_nxt;
            full_r       <= full_nxt;
            rd_valid_r   <= rd_valid_nxt;
        end
    end

    assign load_en       = load_en_r;
    assign opcode        = data_r.opcode;
    assign operand_a     = data_r.operand_a;
    assign operand_b     = data_r.operand_b;
    assign write_pointer = wr_ptr_r;
    assign read_pointer  = rd_ptr_r;
    assign count         = count_r;
    assign full          = full_r;
    assign rd_valid      = rd_valid_r;
    assign last_grant    = last_grant_r;

`ifdef INSTR_CTRL_STATS_EN
    logic [15:0] grant_cnt_a_r;
    logic [15:0] grant_cnt_b_r;
    logic [15:0] full_stall_cnt_r;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_a_r    <= 16'd0;
            grant_cnt_b_r    <= 16'd0;
            full_stall_cnt_r <= 16'd0;
        end else begin
            grant_cnt_a_r    <= sat_inc16(grant_cnt_a_r, grant_a_s);
            grant_cnt_b_r    <= sat_inc16(grant_cnt_b_r, grant_b_s);
            full_stall_cnt_r <= sat_inc16(full_stall_cnt_r, (a_valid || b_valid) && full_r);
        end
    end

    assign grant_cnt_a    = grant_cnt_a_r;
    assign grant_cnt_b    = grant_cnt_b_r;
    assign full_stall_cnt = full_stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Self-checking bench for instr_register_ctrl. A behavioural model keeps the
// accepted instructions as a queue in arrival order; the load-port monitor
// checks each write against the queue of expected writes and stores it in a
// bench copy of the register file, and every pop is checked against the
// oldest expected entry.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;

    logic     clk = 1'b0;
    logic     reset, flush, a_valid, b_valid, rd_ready;
    opcode_t  a_opcode, b_opcode;
    operand_t a_operand_a, a_operand_b, b_operand_a, b_operand_b;
    logic     a_ready, b_ready, load_en, rd_valid, full, last_grant;
    opcode_t  opcode;
    operand_t operand_a, operand_b;
    address_t write_pointer, read_pointer;
    logic [5:0] count;
`ifdef INSTR_CTRL_STATS_EN
    logic [15:0] grant_cnt_a, grant_cnt_b, full_stall_cnt;
`endif

    instr_register_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .a_valid       (a_valid),
        .b_valid       (b_valid),
        .a_ready       (a_ready),
        .b_ready       (b_ready),
        .a_opcode      (a_opcode),
        .a_operand_a   (a_operand_a),
        .a_operand_b   (a_operand_b),
        .b_opcode      (b_opcode),
        .b_operand_a   (b_operand_a),
        .b_operand_b   (b_operand_b),
        .load_en       (load_en),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .count         (count),
        .full          (full),
        .last_grant    (last_grant)
`ifdef INSTR_CTRL_STATS_EN
        ,
        .grant_cnt_a   (grant_cnt_a),
        .grant_cnt_b   (grant_cnt_b),
        .full_stall_cnt(full_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Model state
    typedef struct {
        instr_t d;
        int     addr;
    } wr_t;
    instr_t exp_rd[$];      // accepted, not yet popped, oldest first
    wr_t    exp_wr[$];      // writes expected on the load port
    bit     m_pend  = 1'b0; // newest entry accepted but not yet written
    bit     m_last  = 1'b1;
    bit     m_flush = 1'b0;
    int     m_wr    = 0;
    int     m_rd    = 0;
    bit     mon_en  = 1'b0;
    instr_t mem [DEPTH];

    // {grant_b, grant_a}: lone requester wins, a tie goes to the one not granted last.
    function automatic logic [1:0] exp_grant(input bit en, input bit av, input bit bv, input bit last);
        if (!en) return 2'b00;
        if (av && bv) return last ? 2'b01 : 2'b10;
        return {bv, av};
    endfunction

    function automatic bit model_en();
        return !m_flush && (exp_rd.size() < DEPTH) && !reset;
    endfunction

    // Reference model: advances on each edge using only bench-driven inputs.
    always @(posedge clk) begin
        logic [1:0] g;
        bit         acc, rv, pop;
        instr_t     d;
        g   = exp_grant(model_en(), a_valid, b_valid, m_last);
        acc = g != 2'b00;
        d   = g[1] ? '{b_opcode, b_operand_a, b_operand_b} : '{a_opcode, a_operand_a, a_operand_b};
        rv  = !m_flush && (exp_rd.size() > int'(m_pend));
        pop = rv && rd_ready;
        if (reset) begin
            exp_rd.delete();
            m_pend = 1'b0; m_last = 1'b1; m_flush = 1'b0; m_wr = 0; m_rd = 0;
            mon_en = 1'b1;
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else if (flush) begin
            if (acc) m_last = g[1];
            exp_rd.delete();
            m_pend = 1'b0; m_wr = 0; m_rd = 0; m_flush = 1'b1;
        end else begin
            if (m_pend) m_wr = (m_wr + 1) % DEPTH;
            if (pop) begin
                void'(exp_rd.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (acc) begin
                exp_rd.push_back(d);
                exp_wr.push_back('{d, m_wr});
                m_last = g[1];
            end
            m_pend = acc;
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        logic [1:0] g;
        wr_t        w;
        if (mon_en) begin
            g = exp_grant(model_en(), a_valid, b_valid, m_last);
            chk("a_ready", a_ready, g[0]);
            chk("b_ready", b_ready, g[1]);
            chk("count", count, exp_rd.size());
            chk("full", full, exp_rd.size() == DEPTH);
            chk("rd_valid", rd_valid, !m_flush && (exp_rd.size() > int'(m_pend)));
            chk("load_en", load_en, m_pend);
            chk("write_pointer", write_pointer, m_wr);
            chk("read_pointer", read_pointer, m_rd);
            chk("last_grant", last_grant, m_last);
            if (load_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_opcode", opcode, w.d.opcode);
                    chk("wr_operand_a", operand_a, w.d.operand_a);
                    chk("wr_operand_b", operand_b, w.d.operand_b);
                    chk("wr_addr", write_pointer, w.addr);
                    mem[write_pointer] = '{opcode, operand_a, operand_b};
                end
            end
            if (rd_valid && rd_ready && exp_rd.size() > 0) begin
                chk("pop_entry", mem[read_pointer], exp_rd[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input bit bv, input bit rr, input bit fl, input bit rs);
        a_valid     = av;
        b_valid     = bv;
        rd_ready    = rr;
        flush       = fl;
        reset       = rs;
        a_opcode    = opcode_t'(4'($urandom_range(0, 7)));
        b_opcode    = opcode_t'(4'($urandom_range(0, 7)));
        a_operand_a = $urandom;
        a_operand_b = $urandom;
        b_operand_a = $urandom;
        b_operand_b = $urandom;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Reset held two cycles, then a tie for four cycles: A,B,A,B.
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc(); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (2) cyc();
        // Fill to full, keep requesting, then one pop frees a slot.
        for (int i = 0; i < 31; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc(); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (2) cyc();
        // Flush with five entries and a write in flight, then the same with reset.
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
            for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); end
            drive(1'b0, 1'b0, 1'b0, r == 0, r == 1); cyc();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) cyc();
        end
        // Single ADD 5/3 from A, then drain it.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        a_opcode = ADD; a_operand_a = 32'sd5; a_operand_b = 32'sd3;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (2) cyc();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); repeat (2) cyc();
        // Forty accepts interleaved with pops: pointers wrap past 31.
        for (int i = 0; i < 44; i++) begin drive(i < 40, 1'b0, 1'b1, 1'b0, 1'b0); cyc(); end
        // Random traffic with varying drain pressure, rare flush and reset.
        for (int seg = 0; seg < 4; seg++) begin
            int rp;
            rp = (seg == 0) ? 15 : (seg == 1) ? 50 : (seg == 2) ? 85 : 40;
            for (int i = 0; i < 400; i++) begin
                drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                      $urandom_range(0, 99) < rp, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 299) == 0);
                cyc();
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); repeat (40) cyc();
        @(negedge clk);
        chk("wr_queue_drained", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
